parallel_send: RTL

Transmit-side pattern generator for the serial link test. On each INIT request it pushes a burst of 64-bit words carrying a free-running incrementing count to the serializer, one word per accepted push. The data sequence matches what the receive-side checker expects: it starts at 0 after CLR and continues across bursts. The block sits between the test controller (CLR, INIT) and the serializer's parallel input (ALIGNED, DORDY).

---
 rtl/parallel_send_pkg.sv | 23 ++
 rtl/parallel_send_if.sv | 32 +++
 rtl/parallel_send.sv | 128 ++++++++++++
 3 files changed

// File: rtl/parallel_send_pkg.sv
// -----------------------------------------------------------------------------
// parallel_send_pkg
// Shared definitions for the serial-link test pattern generator. The receive
// side checker imports the same package so both ends agree on the burst length
// and data width.
//   DATA_W        : width of one parallel word (64)
//   BURST_LEN_DEF : default number of words per INIT burst
//   CNT_W_DEF     : default width of the remaining-words counter
//   state_t       : transmit FSM states
// -----------------------------------------------------------------------------
package parallel_send_pkg;

  localparam int DATA_W        = 64;
  localparam int BURST_LEN_DEF = 1024;
  localparam int CNT_W_DEF     = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE_S = 2'd2
  } state_t;

endpackage

// File: rtl/parallel_send_if.sv
// -----------------------------------------------------------------------------
// parallel_send_if
// Parallel word interface between the pattern generator and the serializer.
//   ALIGNED : serializer link aligned (serializer -> generator)
//   DORDY   : serializer can take a word this cycle (serializer -> generator)
//   DOPUSH  : word strobe, one word per high cycle (generator -> serializer)
//   DOUT    : data word, valid while DOPUSH=1 (generator -> serializer)
// Modports: master = generator side, slave = serializer side.
// -----------------------------------------------------------------------------
interface parallel_send_if;
  import parallel_send_pkg::*;

  logic              ALIGNED;
  logic              DORDY;
  logic              DOPUSH;
  logic [DATA_W-1:0] DOUT;

  modport master (
    input  ALIGNED,
    input  DORDY,
    output DOPUSH,
    output DOUT
  );

  modport slave (
    output ALIGNED,
    output DORDY,
    input  DOPUSH,
    input  DOUT
  );

endinterface

// File: rtl/parallel_send.sv
// -----------------------------------------------------------------------------
// parallel_send
// Transmit-side pattern generator for the serial link test. Each INIT request
// pushes a burst of BURST_LEN words carrying a free-running 64-bit count to the
// serializer. The count starts at 0 after RST/CLR and continues across bursts.
//
// Ports:
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset
//   CLR      : synchronous clear, same effect as RST
//   INIT     : single-cycle burst request (also reloads a running burst)
//   ERR_INJ  : corrupt the next pushed word (only with PARALLEL_SEND_ERR_INJ_EN)
//   BUSY     : burst in progress; high from the cycle after INIT until DONE
//   DONE     : one-cycle pulse in the cycle after the last pushed word
//   ser      : parallel_send_if.master (ALIGNED, DORDY in; DOPUSH, DOUT out)
//
// Optional feature macro: PARALLEL_SEND_ERR_INJ_EN adds the ERR_INJ port and a
// sticky inject flag that flips bit 0 of the next pushed word.
// -----------------------------------------------------------------------------
module parallel_send
  import parallel_send_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic INIT,
`ifdef PARALLEL_SEND_ERR_INJ_EN
  input  logic ERR_INJ,
`endif
  output logic BUSY,
  output logic DONE,
  parallel_send_if.master ser
);

  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_LEN);

  state_t            state;
  logic [DATA_W-1:0] data_cnt;
  logic [CNT_W-1:0]  remaining;
  logic              push_q;
  logic [DATA_W-1:0] dout_next;

  // A word goes out on every cycle the burst is active and the serializer is
  // both aligned and ready; otherwise everything holds.
  assign push_q = (state == SEND) && ser.ALIGNED && ser.DORDY;

`ifdef PARALLEL_SEND_ERR_INJ_EN
  logic inj_flag;

  // The flag is consumed by the next pushed word. A request arriving in the
  // consuming cycle re-arms it for the following word.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      inj_flag <= 1'b0;
    end else begin
      inj_flag <= ERR_INJ || (inj_flag && !push_q);
    end
  end

  // Only the word on the wire is corrupted; data_cnt advances normally, so the
  // receiver sees exactly one bad word per injection.
  assign dout_next = data_cnt ^ {{(DATA_W-1){1'b0}}, inj_flag};
`else
  assign dout_next = data_cnt;
`endif

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      state      <= IDLE;
      data_cnt   <= '0;
      remaining  <= '0;
      ser.DOPUSH <= 1'b0;
      ser.DOUT   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      ser.DOPUSH <= 1'b0;
      DONE       <= 1'b0;

      case (state)
        IDLE: begin
          if (INIT) begin
            remaining <= BURST_LOAD;
            BUSY      <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          if (push_q) begin
            ser.DOPUSH <= 1'b1;
            ser.DOUT   <= dout_next;
            data_cnt   <= data_cnt + DATA_W'(1);
            remaining  <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DONE_S;
            end
          end
        end

        // BUSY stays high through the cycle that carries the last word and
        // drops together with the DONE pulse.
        DONE_S: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // NOTE: a later non-blocking assignment to the same flop in this block
      // wins, so this reload overrides the decrement and state change above
      // while any word pushed this cycle still goes out and counts.
      if (INIT && (state != IDLE)) begin
        remaining <= BURST_LOAD;
        BUSY      <= 1'b1;
        state     <= SEND;
      end
    end
  end

endmodule
